// File: rtl/regfile_wb_arb_pkg.sv
// Shared CPU register-file package.
// Holds the register-file geometry used by the writeback arbiter, the
// scoreboard and the register file itself, plus the writeback source type
// that tells the scoreboard which commits retire an outstanding MDU op.
package regfile_wb_arb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;
  localparam int STARVE_W   = 4;

  // Origin of the write currently held in the output register.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_PIPE = 2'd1,
    SRC_MDU  = 2'd2
  } wb_src_e;

endpackage

// File: rtl/regfile_wb_arb_scoreboard.sv
// Pending-write scoreboard for the register file.
// A bit is set when an MDU operation issues to a register and cleared when
// that MDU result commits. Decode stalls on any source or issue destination
// whose register still has an MDU write outstanding.
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   set_en, set_wa   MDU issue: mark set_wa pending
//   clr_en, clr_wa   MDU commit: clear clr_wa
//   ra1, ra2         decode source registers
//   busy             pending bit per register (bit 0 always 0)
//   stall            combinational decode hazard
module regfile_scoreboard
  import regfile_wb_arb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_wa,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_wa,
  input  logic [REG_ADDR_W-1:0] ra1,
  input  logic [REG_ADDR_W-1:0] ra2,
  output logic [NUM_REGS-1:0]   busy,
  output logic                  stall
);

  logic [NUM_REGS-1:0] busy_q, busy_d;

  // Clear is applied before set so a same-edge issue to the register being
  // retired leaves it pending (the new op has not completed yet).
  always_comb begin
    busy_d = busy_q;
    if (clr_en) begin
      busy_d[clr_wa] = 1'b0;
    end
    if (set_en && (set_wa != '0)) begin
      busy_d[set_wa] = 1'b1;
    end
    busy_d[0] = 1'b0;
    if (rst) begin
      busy_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    busy_q <= busy_d;
  end

  assign busy = busy_q;

  // r0 is hardwired so it never creates a hazard; a new issue to a register
  // that is already pending would otherwise lose track of the older op.
  assign stall = ((ra1 != '0) && busy_q[ra1]) ||
                 ((ra2 != '0) && busy_q[ra2]) ||
                 (set_en && (set_wa != '0) && busy_q[set_wa]);

endmodule

// File: rtl/regfile_wb_arb.sv
// Register-file writeback arbiter.
// Merges pipeline and multiply/divide-unit writebacks onto the single
// register-file write port. The pipe normally wins; an MDU request held off
// for STARVE_MAX consecutive cycles is forced through. The granted write is
// registered onto rf_we/rf_wa/rf_wd, and a scoreboard tracks MDU results
// still in flight.
// Ports:
//   clk, rst                   clock and synchronous active-high reset
//   pipe_valid/wa/wd, pipe_ready   pipeline writeback handshake
//   mdu_valid/wa/wd, mdu_ready     MDU writeback handshake
//   iss_valid, iss_wa          MDU issue (marks destination pending)
//   ra1, ra2                   decode source registers
//   rf_we, rf_wa, rf_wd        registered register-file write port
//   busy                       pending-write scoreboard
//   stall                      combinational decode hazard
module regfile_wb_arb
  import regfile_wb_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pipe_valid,
  input  logic [REG_ADDR_W-1:0] pipe_wa,
  input  logic [DATA_W-1:0]     pipe_wd,
  output logic                  pipe_ready,
  input  logic                  mdu_valid,
  input  logic [REG_ADDR_W-1:0] mdu_wa,
  input  logic [DATA_W-1:0]     mdu_wd,
  output logic                  mdu_ready,
  input  logic                  iss_valid,
  input  logic [REG_ADDR_W-1:0] iss_wa,
  input  logic [REG_ADDR_W-1:0] ra1,
  input  logic [REG_ADDR_W-1:0] ra2,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_wa,
  output logic [DATA_W-1:0]     rf_wd,
  output logic [NUM_REGS-1:0]   busy,
  output logic                  stall
);

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0]   starve_q, starve_d;
  logic                  rf_we_q, rf_we_d;
  logic [REG_ADDR_W-1:0] rf_wa_q, rf_wa_d;
  logic [DATA_W-1:0]     rf_wd_q, rf_wd_d;
  wb_src_e               src_q, src_d;

  wb_src_e               grant_src;
  logic [REG_ADDR_W-1:0] grant_wa;
  logic [DATA_W-1:0]     grant_wd;

  // Ready is purely a function of this cycle's valids and the starvation
  // count, so a lone requester is granted with no bubble.
  always_comb begin
    pipe_ready = 1'b0;
    mdu_ready  = 1'b0;
    if (!rst) begin
      if (mdu_valid && (starve_q == STARVE_LIM)) begin
        mdu_ready = 1'b1;
      end else if (pipe_valid) begin
        pipe_ready = 1'b1;
      end else if (mdu_valid) begin
        mdu_ready = 1'b1;
      end
    end
  end

  // Select the granted request and form the next output-register contents.
  // A write to r0 is accepted but never reaches the register file, and the
  // address/data registers keep their last real write.
  always_comb begin
    grant_src = SRC_NONE;
    grant_wa  = pipe_wa;
    grant_wd  = pipe_wd;
    if (pipe_valid && pipe_ready) begin
      grant_src = SRC_PIPE;
    end else if (mdu_valid && mdu_ready) begin
      grant_src = SRC_MDU;
      grant_wa  = mdu_wa;
      grant_wd  = mdu_wd;
    end

    rf_we_d = 1'b0;
    rf_wa_d = rf_wa_q;
    rf_wd_d = rf_wd_q;
    src_d   = SRC_NONE;
    if ((grant_src != SRC_NONE) && (grant_wa != '0)) begin
      rf_we_d = 1'b1;
      rf_wa_d = grant_wa;
      rf_wd_d = grant_wd;
      src_d   = grant_src;
    end

    // The count only grows while the MDU is actually waiting.
    starve_d = starve_q;
    if (!mdu_valid || mdu_ready) begin
      starve_d = '0;
    end else if (starve_q < STARVE_LIM) begin
      starve_d = starve_q + 1'b1;
    end

    if (rst) begin
      rf_we_d  = 1'b0;
      rf_wa_d  = '0;
      rf_wd_d  = '0;
      src_d    = SRC_NONE;
      starve_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    starve_q <= starve_d;
    rf_we_q  <= rf_we_d;
    rf_wa_q  <= rf_wa_d;
    rf_wd_q  <= rf_wd_d;
    src_q    <= src_d;
  end

  assign rf_we = rf_we_q;
  assign rf_wa = rf_wa_q;
  assign rf_wd = rf_wd_q;

  // Only MDU commits retire a pending entry; pipe writes to a pending
  // register leave the outstanding MDU op tracked.
  regfile_scoreboard u_scoreboard (
    .clk    (clk),
    .rst    (rst),
    .set_en (iss_valid),
    .set_wa (iss_wa),
    .clr_en (rf_we_q && (src_q == SRC_MDU)),
    .clr_wa (rf_wa_q),
    .ra1    (ra1),
    .ra2    (ra2),
    .busy   (busy),
    .stall  (stall)
  );

endmodule

// File: tb/tb_regfile_wb_arb.sv
// Testbench for regfile_wb_arb: directed scenarios plus randomized traffic,
// all checked against a cycle-level behavioural model kept in this file.
module tb_regfile_wb_arb;

  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_valid, mdu_valid, iss_valid;
  logic [4:0]  pipe_wa, mdu_wa, iss_wa, ra1, ra2;
  logic [31:0] pipe_wd, mdu_wd;
  logic        pipe_ready, mdu_ready, rf_we, stall;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd, busy;

  regfile_wb_arb #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk        (clk),
    .rst        (rst),
    .pipe_valid (pipe_valid),
    .pipe_wa    (pipe_wa),
    .pipe_wd    (pipe_wd),
    .pipe_ready (pipe_ready),
    .mdu_valid  (mdu_valid),
    .mdu_wa     (mdu_wa),
    .mdu_wd     (mdu_wd),
    .mdu_ready  (mdu_ready),
    .iss_valid  (iss_valid),
    .iss_wa     (iss_wa),
    .ra1        (ra1),
    .ra2        (ra2),
    .rf_we      (rf_we),
    .rf_wa      (rf_wa),
    .rf_wd      (rf_wd),
    .busy       (busy),
    .stall      (stall)
  );

  always #5 clk = ~clk;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  // Behavioural model state: what the write port and scoreboard should hold.
  logic        m_we       = 1'b0;
  logic [4:0]  m_wa       = '0;
  logic [31:0] m_wd       = '0;
  logic        m_from_mdu = 1'b0;
  logic [31:0] m_busy     = '0;
  int          m_starve   = 0;
  logic        exp_pr, exp_mr, exp_stall;

  task automatic idle_inputs();
    rst = 1'b0;
    pipe_valid = 1'b0; pipe_wa = '0; pipe_wd = '0;
    mdu_valid  = 1'b0; mdu_wa  = '0; mdu_wd  = '0;
    iss_valid  = 1'b0; iss_wa  = '0;
    ra1 = '0; ra2 = '0;
  endtask

  // Expected combinational outputs for the inputs currently driven.
  task automatic model_eval();
    exp_pr = 1'b0;
    exp_mr = 1'b0;
    if (!rst) begin
      if (mdu_valid && m_starve == STARVE_MAX) exp_mr = 1'b1;
      else if (pipe_valid) exp_pr = 1'b1;
      else if (mdu_valid) exp_mr = 1'b1;
    end
    exp_stall = (ra1 != 0 && m_busy[ra1]) || (ra2 != 0 && m_busy[ra2]) ||
                (iss_valid && iss_wa != 0 && m_busy[iss_wa]);
  endtask

  // Advance the model across the coming clock edge.
  task automatic model_commit();
    if (rst) begin
      m_we = 1'b0; m_wa = '0; m_wd = '0; m_from_mdu = 1'b0;
      m_busy = '0; m_starve = 0;
    end else begin
      if (m_we && m_from_mdu) m_busy[m_wa] = 1'b0;
      if (iss_valid && iss_wa != 0) m_busy[iss_wa] = 1'b1;
      if (exp_pr) begin
        m_we = (pipe_wa != 0);
        if (m_we) begin m_wa = pipe_wa; m_wd = pipe_wd; end
        m_from_mdu = 1'b0;
      end else if (exp_mr) begin
        m_we = (mdu_wa != 0);
        if (m_we) begin m_wa = mdu_wa; m_wd = mdu_wd; end
        m_from_mdu = 1'b1;
      end else begin
        m_we = 1'b0;
      end
      if (!mdu_valid || exp_mr) m_starve = 0;
      else if (m_starve < STARVE_MAX) m_starve++;
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1; pipe_valid = 1'b1; pipe_wa = 5'd3; mdu_valid = 1'b1; mdu_wa = 5'd4;
    iss_valid = 1'b1; iss_wa = 5'd6;
    @(negedge clk); #1;
    model_eval();
    assert_cnt++; if (rf_we !== 1'b0) begin fail_cnt++; $display("[TB] FAIL reset_rf_we: got %b want 0", rf_we); end
    assert_cnt++; if (rf_wa !== 5'd0) begin fail_cnt++; $display("[TB] FAIL reset_rf_wa: got %0d want 0", rf_wa); end
    assert_cnt++; if (rf_wd !== 32'd0) begin fail_cnt++; $display("[TB] FAIL reset_rf_wd: got %h want 0", rf_wd); end
    assert_cnt++; if (busy !== 32'd0) begin fail_cnt++; $display("[TB] FAIL reset_busy: got %h want 0", busy); end
    assert_cnt++; if (pipe_ready !== 1'b0) begin fail_cnt++; $display("[TB] FAIL reset_pipe_ready: got %b want 0", pipe_ready); end
    assert_cnt++; if (mdu_ready !== 1'b0) begin fail_cnt++; $display("[TB] FAIL reset_mdu_ready: got %b want 0", mdu_ready); end
    model_commit();
    @(negedge clk); idle_inputs(); #1;
    model_eval();
    assert_cnt++; if (rf_we !== 1'b0) begin fail_cnt++; $display("[TB] FAIL reset_no_grant: got %b want 0", rf_we); end
    model_commit();
  endtask

  task automatic test_mdu_only();
    @(negedge clk); idle_inputs(); mdu_valid = 1'b1; mdu_wa = 5'd2; mdu_wd = 32'hABCD; #1;
    model_eval();
    assert_cnt++; if (mdu_ready !== 1'b1) begin fail_cnt++; $display("[TB] FAIL mdu_only_ready: got %b want 1", mdu_ready); end
    assert_cnt++; if (pipe_ready !== 1'b0) begin fail_cnt++; $display("[TB] FAIL mdu_only_pipe_ready: got %b want 0", pipe_ready); end
    model_commit();
    @(negedge clk); idle_inputs(); #1;
    model_eval();
    assert_cnt++; if ({rf_we, rf_wa, rf_wd} !== {1'b1, 5'd2, 32'hABCD}) begin
      fail_cnt++; $display("[TB] FAIL mdu_only_write: got we=%b wa=%0d wd=%h want we=1 wa=2 wd=0000abcd", rf_we, rf_wa, rf_wd); end
    model_commit();
    @(negedge clk); idle_inputs(); #1;
    model_eval();
    assert_cnt++; if ({rf_we, rf_wa, rf_wd} !== {1'b0, 5'd2, 32'hABCD}) begin
      fail_cnt++; $display("[TB] FAIL idle_hold: got we=%b wa=%0d wd=%h want we=0 wa=2 wd=0000abcd", rf_we, rf_wa, rf_wd); end
    model_commit();
  endtask

  task automatic test_starvation();
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk); idle_inputs();
      pipe_valid = 1'b1; pipe_wa = 5'd3; pipe_wd = 32'h11;
      mdu_valid  = 1'b1; mdu_wa  = 5'd5; mdu_wd  = 32'h22; #1;
      model_eval();
      assert_cnt++; if (pipe_ready !== (c <= 4)) begin fail_cnt++; $display("[TB] FAIL starve_pipe_ready c%0d: got %b want %b", c, pipe_ready, (c <= 4)); end
      assert_cnt++; if (mdu_ready !== (c == 5)) begin fail_cnt++; $display("[TB] FAIL starve_mdu_ready c%0d: got %b want %b", c, mdu_ready, (c == 5)); end
      if (c >= 2) begin
        assert_cnt++; if ({rf_we, rf_wa, rf_wd} !== {1'b1, 5'd3, 32'h11}) begin
          fail_cnt++; $display("[TB] FAIL starve_pipe_write c%0d: got we=%b wa=%0d wd=%h want we=1 wa=3 wd=11", c, rf_we, rf_wa, rf_wd); end
      end
      model_commit();
    end
    @(negedge clk); idle_inputs(); #1;
    model_eval();
    assert_cnt++; if ({rf_we, rf_wa, rf_wd} !== {1'b1, 5'd5, 32'h22}) begin
      fail_cnt++; $display("[TB] FAIL starve_mdu_write: got we=%b wa=%0d wd=%h want we=1 wa=5 wd=22", rf_we, rf_wa, rf_wd); end
    model_commit();
  endtask

  task automatic test_hazard();
    @(negedge clk); idle_inputs(); iss_valid = 1'b1; iss_wa = 5'd7; #1;
    model_eval();
    assert_cnt++; if (stall !== 1'b0) begin fail_cnt++; $display("[TB] FAIL hazard_issue_free: got %b want 0", stall); end
    model_commit();
    @(negedge clk); idle_inputs(); ra1 = 5'd7; #1;
    model_eval();
    assert_cnt++; if (stall !== 1'b1) begin fail_cnt++; $display("[TB] FAIL hazard_ra1: got %b want 1", stall); end
    assert_cnt++; if (busy !== 32'h80) begin fail_cnt++; $display("[TB] FAIL hazard_busy: got %h want 00000080", busy); end
    model_commit();
    @(negedge clk); idle_inputs(); iss_valid = 1'b1; iss_wa = 5'd7; #1;
    model_eval();
    assert_cnt++; if (stall !== 1'b1) begin fail_cnt++; $display("[TB] FAIL hazard_reissue: got %b want 1", stall); end
    model_commit();
    @(negedge clk); idle_inputs(); ra1 = 5'd7; mdu_valid = 1'b1; mdu_wa = 5'd7; mdu_wd = 32'h77; #1;
    model_eval();
    assert_cnt++; if (stall !== 1'b1 || mdu_ready !== 1'b1) begin
      fail_cnt++; $display("[TB] FAIL hazard_mdu_grant: got stall=%b ready=%b want 1 1", stall, mdu_ready); end
    model_commit();
    @(negedge clk); idle_inputs(); ra2 = 5'd7; #1;
    model_eval();
    assert_cnt++; if ({rf_we, rf_wa, stall} !== {1'b1, 5'd7, 1'b1}) begin
      fail_cnt++; $display("[TB] FAIL hazard_commit_cycle: got we=%b wa=%0d stall=%b want 1 7 1", rf_we, rf_wa, stall); end
    model_commit();
    @(negedge clk); idle_inputs(); ra1 = 5'd7; ra2 = 5'd7; #1;
    model_eval();
    assert_cnt++; if (stall !== 1'b0 || busy[7] !== 1'b0) begin
      fail_cnt++; $display("[TB] FAIL hazard_cleared: got stall=%b busy7=%b want 0 0", stall, busy[7]); end
    model_commit();
  endtask

  task automatic test_zero_wa();
    @(negedge clk); idle_inputs(); pipe_valid = 1'b1; pipe_wa = 5'd0; pipe_wd = 32'hFFFF_FFFF; #1;
    model_eval();
    assert_cnt++; if (pipe_ready !== 1'b1) begin fail_cnt++; $display("[TB] FAIL zero_wa_ready: got %b want 1", pipe_ready); end
    model_commit();
    @(negedge clk); idle_inputs(); #1;
    model_eval();
    assert_cnt++; if (rf_we !== 1'b0) begin fail_cnt++; $display("[TB] FAIL zero_wa_we: got %b want 0", rf_we); end
    assert_cnt++; if (busy !== m_busy) begin fail_cnt++; $display("[TB] FAIL zero_wa_busy: got %h want %h", busy, m_busy); end
    model_commit();
  endtask

  task automatic test_collision();
    @(negedge clk); idle_inputs(); mdu_valid = 1'b1; mdu_wa = 5'd9; mdu_wd = 32'h99; #1;
    model_eval();
    assert_cnt++; if (mdu_ready !== 1'b1) begin fail_cnt++; $display("[TB] FAIL collide_grant: got %b want 1", mdu_ready); end
    model_commit();
    @(negedge clk); idle_inputs(); iss_valid = 1'b1; iss_wa = 5'd9; #1;
    model_eval();
    assert_cnt++; if ({rf_we, rf_wa} !== {1'b1, 5'd9}) begin fail_cnt++; $display("[TB] FAIL collide_commit: got we=%b wa=%0d want 1 9", rf_we, rf_wa); end
    model_commit();
    @(negedge clk); idle_inputs(); #1;
    model_eval();
    assert_cnt++; if (busy[9] !== 1'b1) begin fail_cnt++; $display("[TB] FAIL collide_set_wins: got %b want 1", busy[9]); end
    model_commit();
    @(negedge clk); idle_inputs(); pipe_valid = 1'b1; pipe_wa = 5'd9; pipe_wd = 32'h1234; #1;
    model_eval();
    assert_cnt++; if (pipe_ready !== 1'b1) begin fail_cnt++; $display("[TB] FAIL pipe_busy_ready: got %b want 1", pipe_ready); end
    model_commit();
    @(negedge clk); idle_inputs(); #1;
    model_eval();
    assert_cnt++; if ({rf_we, rf_wa, rf_wd} !== {1'b1, 5'd9, 32'h1234}) begin
      fail_cnt++; $display("[TB] FAIL pipe_busy_write: got we=%b wa=%0d wd=%h want 1 9 1234", rf_we, rf_wa, rf_wd); end
    model_commit();
    @(negedge clk); idle_inputs(); #1;
    model_eval();
    assert_cnt++; if (busy[9] !== 1'b1) begin fail_cnt++; $display("[TB] FAIL pipe_busy_kept: got %b want 1", busy[9]); end
    model_commit();
  endtask

  task automatic test_reset_inflight();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); idle_inputs(); iss_valid = 1'b1; iss_wa = (k == 0) ? 5'd8 : (k == 1) ? 5'd10 : 5'd11; #1;
      model_eval(); model_commit();
    end
    @(negedge clk); idle_inputs(); pipe_valid = 1'b1; pipe_wa = 5'd4; pipe_wd = 32'h44; #1;
    model_eval();
    assert_cnt++; if (busy !== 32'h0000_0F00) begin fail_cnt++; $display("[TB] FAIL inflight_busy: got %h want 00000f00", busy); end
    model_commit();
    @(negedge clk); idle_inputs(); rst = 1'b1; pipe_valid = 1'b1; pipe_wa = 5'd6; mdu_valid = 1'b1; mdu_wa = 5'd6; #1;
    model_eval();
    assert_cnt++; if ({pipe_ready, mdu_ready, rf_we} !== 3'b001) begin
      fail_cnt++; $display("[TB] FAIL inflight_rst_rise: got pr=%b mr=%b we=%b want 0 0 1", pipe_ready, mdu_ready, rf_we); end
    model_commit();
    @(negedge clk); #1;
    model_eval();
    assert_cnt++; if ({busy, rf_we, pipe_ready, mdu_ready} !== {32'd0, 3'b000}) begin
      fail_cnt++; $display("[TB] FAIL inflight_rst_state: got busy=%h we=%b pr=%b mr=%b want 0 0 0 0", busy, rf_we, pipe_ready, mdu_ready); end
    model_commit();
    @(negedge clk); idle_inputs(); #1;
    model_eval();
    assert_cnt++; if (rf_we !== 1'b0) begin fail_cnt++; $display("[TB] FAIL inflight_discard: got %b want 0", rf_we); end
    model_commit();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      rst        = ($urandom_range(0, 39) == 0);
      pipe_valid = ($urandom_range(0, 3) != 0);
      pipe_wa    = 5'($urandom_range(0, 7));
      pipe_wd    = $urandom;
      mdu_valid  = ($urandom_range(0, 3) != 0);
      mdu_wa     = 5'($urandom_range(0, 7));
      mdu_wd     = $urandom;
      iss_valid  = ($urandom_range(0, 3) == 0);
      iss_wa     = 5'($urandom_range(0, 7));
      ra1        = 5'($urandom_range(0, 7));
      ra2        = 5'($urandom_range(0, 7));
      #1;
      model_eval();
      assert_cnt++; if ({pipe_ready, mdu_ready} !== {exp_pr, exp_mr}) begin
        fail_cnt++; $display("[TB] FAIL rand_ready n%0d: got pr=%b mr=%b want %b %b", n, pipe_ready, mdu_ready, exp_pr, exp_mr); end
      assert_cnt++; if (stall !== exp_stall) begin fail_cnt++; $display("[TB] FAIL rand_stall n%0d: got %b want %b", n, stall, exp_stall); end
      assert_cnt++; if (busy !== m_busy) begin fail_cnt++; $display("[TB] FAIL rand_busy n%0d: got %h want %h", n, busy, m_busy); end
      assert_cnt++; if (rf_we !== m_we) begin fail_cnt++; $display("[TB] FAIL rand_we n%0d: got %b want %b", n, rf_we, m_we); end
      if (m_we) begin
        assert_cnt++; if ({rf_wa, rf_wd} !== {m_wa, m_wd}) begin
          fail_cnt++; $display("[TB] FAIL rand_write n%0d: got wa=%0d wd=%h want wa=%0d wd=%h", n, rf_wa, rf_wd, m_wa, m_wd); end
      end
      model_commit();
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_mdu_only();
    test_starvation();
    test_hazard();
    test_zero_wa();
    test_collision();
    test_reset_inflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arb.md
REGFILE_WB_ARB -- requirements
Module: regfile_wb_arb

Interface
REQ-001 SHALL have parameter: STARVE_MAX, 4, max consecutive cycles an MDU request may be held off by the pipe (legal range 1..15).
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
  clk  in  1  single clock; all state updates on posedge clk.
  rst  in  1  synchronous, active-high reset.
  pipe_valid  in  1  pipeline writeback request.
  pipe_wa  in  5  pipeline destination register.
  pipe_wd  in  32  pipeline write data.
  pipe_ready  out  1  pipeline request granted this cycle (combinational).
  mdu_valid  in  1  multiply/divide unit writeback request.
  mdu_wa  in  5  MDU destination register.
  mdu_wd  in  32  MDU write data.
  mdu_ready  out  1  MDU request granted this cycle (combinational).
  iss_valid  in  1  MDU operation issued; marks iss_wa pending.
  iss_wa  in  5  destination of the issued MDU operation.
  ra1, ra2  in  5 each  decode-stage source registers for hazard check.
  rf_we  out  1  register file write enable (registered).
  rf_wa  out  5  register file write address (registered).
  rf_wd  out  32  register file write data (registered).
  busy  out  32  pending-write scoreboard, bit n = register n pending.
  stall  out  1  decode hazard (combinational).

Function
REQ-003 SHALL grant at most one requester per cycle; a transfer occurs when valid and ready are both high.
REQ-004 SHALL give the pipe priority, except when the starvation counter equals STARVE_MAX and mdu_valid is high, in which case mdu_ready=1 and pipe_ready=0 that cycle.
REQ-005 SHALL keep a 4-bit starvation counter: +1 (saturating at STARVE_MAX) in each cycle mdu_valid=1 and mdu_ready=0; cleared to 0 on any MDU grant or any cycle mdu_valid=0.
REQ-006 SHALL assert ready for a sole valid requester in the same cycle (no idle bubble).
REQ-007 SHALL register the granted request: grant in cycle N gives rf_we=1 with that wa/wd in cycle N+1; no grant gives rf_we=0 in N+1, rf_wa/rf_wd holding their previous values.
REQ-008 SHALL accept (ready=1) requests with wa=0 but produce rf_we=0 for them; they still count as grants for REQ-005.
REQ-009 SHALL set busy[iss_wa] at the clock edge ending a cycle with iss_valid=1 and iss_wa!=0; busy[0] is always 0.
REQ-010 SHALL clear busy[n] at the clock edge ending a cycle with rf_we=1 and rf_wa=n, so the bit reads 0 from the cycle after the register file commits.
REQ-011 SHALL give set priority when set and clear target the same register at the same edge.
REQ-012 SHALL drive stall = (ra1!=0 and busy[ra1]) or (ra2!=0 and busy[ra2]) or (iss_valid and iss_wa!=0 and busy[iss_wa]).
REQ-013 SHALL not modify busy for pipe writes; a pipe write to a busy register is committed and leaves busy unchanged.
REQ-014 SHALL produce no X on outputs when inputs are known.

Reset
REQ-015 SHALL, in any cycle with rst=1, force next state: rf_we=0, rf_wa=0, rf_wd=0, busy=0, starvation counter=0.
REQ-016 SHALL hold pipe_ready=0 and mdu_ready=0 while rst=1; a request presented during reset is not granted.
REQ-017 SHALL discard a grant registered in the cycle rst rises (rf_we=0 the next cycle).

Structure
REQ-018 SHALL place the REG_ADDR_W=5, DATA_W=32, NUM_REGS=32 constants in the shared CPU package used by the register file.
REQ-019 SHALL implement the scoreboard as one sub-module, regfile_scoreboard (busy vector, set/clear, stall logic); arbitration and output registers stay in the top.

Verification
REQ-020 Both valid, pipe wa=3 wd=0x11, mdu wa=5 wd=0x22, pipe held valid -> pipe granted 4 cycles, MDU granted in the 5th, rf_we with wa=5 wd=0x22 in the 6th.
REQ-021 iss_valid with iss_wa=7, then ra1=7 -> stall=1 until mdu write wa=7 commits; stall=0 the cycle after rf_we with rf_wa=7.
REQ-022 pipe_valid wa=0 wd=0xFFFFFFFF -> pipe_ready=1, rf_we=0 next cycle, busy unchanged.
REQ-023 Set busy[9] via issue while rf_we=1 rf_wa=9 clears at the same edge -> busy[9]=1 afterwards.
REQ-024 rst=1 with busy=0x0000_0F00 and a grant in flight -> next cycle busy=0, rf_we=0, both ready=0 while rst=1.
REQ-025 Only mdu_valid (wa=2 wd=0xABCD) -> mdu_ready=1 same cycle, rf_we=1 wa=2 wd=0xABCD next cycle.
